fifo_wr_arbiter: RTL

//   Round-robin arbiter sharing the single write port of FIFO_top among N_REQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_sel.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  parameter int unsigned N_REQ_MAX = 8;

  typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

  // Round-robin successor of id among n requesters.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_sel.sv
// Rotating priority select: first valid requester at or after ptr, plus an any-valid flag.
module rr_priority_sel
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any_valid
);
  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0] rot;
  logic [IdW:0] sum;

  always_comb begin
    // rot[0] is requester ptr, rot[1] is ptr+1, ... (mod N)
    rot       = N'({valid, valid} >> ptr);
    any_valid = |rot;
    sum       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (IdW + 1)'(i);
      end
    end
    if (sum >= (IdW + 1)'(N)) begin
      sum = sum - (IdW + 1)'(N);
    end
    gnt_id = sum[IdW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the shared FIFO write port, gated by the FIFO full flag.
// Define FIFO_WR_ARB_BURST_EN to let a grant hold the port for up to BURST_LEN beats.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      i_wclk,
  input  logic                      i_wrst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wren,
  output logic [DATA_W-1:0]         o_fifo_wdata,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic [CNT_W-1:0]          o_wr_count
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [IdW-1:0] rr_ptr;
  logic [IdW-1:0] sel_id;
  logic [IdW-1:0] g;
  logic [IdW-1:0] rel_ptr;
  logic           any_valid;
  logic           cand_valid;
  logic           end_grant;
  logic           release_lock;
  logic           xfer;

  function automatic logic [IdW-1:0] ptr_after(input logic [IdW-1:0] id);
    return IdW'(rr_next(32'(id), N_REQ));
  endfunction

  rr_priority_sel #(
    .N (N_REQ)
  ) u_sel (
    .valid     (i_req_valid),
    .ptr       (rr_ptr),
    .gnt_id    (sel_id),
    .any_valid (any_valid)
  );

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int unsigned BcW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic           lock;
  logic [IdW-1:0] lock_id;
  logic [BcW-1:0] beat_cnt;

  assign g            = lock ? lock_id : sel_id;
  assign cand_valid   = lock ? i_req_valid[lock_id] : any_valid;
  assign end_grant    = (beat_cnt == BcW'(BURST_LEN - 1));
  assign release_lock = lock & ~i_req_valid[lock_id];
  assign rel_ptr      = lock_id;

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      lock     <= 1'b0;
      lock_id  <= '0;
      beat_cnt <= '0;
    end else if (xfer) begin
      if (end_grant) begin
        lock     <= 1'b0;
        beat_cnt <= '0;
      end else begin
        lock     <= 1'b1;
        lock_id  <= g;
        beat_cnt <= beat_cnt + BcW'(1);
      end
    end else if (release_lock) begin
      // Locked requester went idle: give up the rest of its burst.
      lock     <= 1'b0;
      beat_cnt <= '0;
    end
  end
`else
  assign g            = sel_id;
  assign cand_valid   = any_valid;
  assign end_grant    = 1'b1;
  assign release_lock = 1'b0;
  assign rel_ptr      = sel_id;
`endif

  // Full and reset both suppress the transfer in the same cycle, so no beat is lost.
  assign xfer = cand_valid & ~i_fifo_full & i_wrst_n;

  always_comb begin
    o_req_ready  = '0;
    o_fifo_wren  = xfer;
    o_fifo_wdata = '0;
    if (xfer) begin
      o_req_ready[g] = 1'b1;
      o_fifo_wdata   = i_req_data[int'(g) * DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      rr_ptr     <= '0;
      o_grant_id <= '0;
      o_wr_count <= '0;
    end else if (xfer) begin
      o_wr_count <= o_wr_count + CNT_W'(1);
      o_grant_id <= g;
      if (end_grant) begin
        rr_ptr <= ptr_after(g);
      end
    end else if (release_lock) begin
      rr_ptr <= ptr_after(rel_ptr);
    end
  end

endmodule
